// File: rtl/avg_pkg.sv
// avg_pkg -- shared definitions for the frame averaging scheduler.
//   state_t : scheduler FSM states (IDLE, ACC, SHIFT, DONE)
//   NS_DEF  : default samples per frame (power of two)
//   NSH_DEF : default number of shift passes per frame
package avg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACC   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int NS_DEF  = 8;
   localparam int NSH_DEF = 3;

endpackage

// File: rtl/avg_dp.sv
// avg_dp -- accumulator datapath with one shared adder and one shared
// logical right shifter.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : synchronous clear of the accumulator
//   load         : acc <= zext(din), capture sa into sa_q
//   add          : acc <= acc + zext(din)
//   shift        : acc <= acc >> sa_q (0 when sa_q >= AW)
//   din, sa      : sample value and shift amount
//   shifted      : combinational acc >> sa_q, used for the result
module avg_dp #(
   parameter int DW = 16,
   parameter int AW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          load,
   input  logic          add,
   input  logic          shift,
   input  logic [DW-1:0] din,
   input  logic [7:0]    sa,
   output logic [AW-1:0] shifted
);

   // Shift amounts at or beyond this limit flush the accumulator to zero.
   localparam logic [8:0] SA_LIM = (AW > 255) ? 9'd256 : 9'(AW);

   logic [AW-1:0] acc_r;
   logic [7:0]    sa_q_r;
   logic [AW-1:0] add_a_s;
   logic [AW-1:0] sum_s;

   // Single adder: a load is an add onto zero, so both share it.
   always_comb begin
      add_a_s = load ? {AW{1'b0}} : acc_r;
      sum_s   = add_a_s + AW'(din);
   end

   // Single logical right shifter with out-of-range flush.
   always_comb begin
      if ({1'b0, sa_q_r} >= SA_LIM) begin
         shifted = {AW{1'b0}};
      end else begin
         shifted = acc_r >> sa_q_r;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r <= {AW{1'b0}};
      end else if (clr) begin
         acc_r <= {AW{1'b0}};
      end else if (load || add) begin
         acc_r <= sum_s;
      end else if (shift) begin
         acc_r <= shifted;
      end
   end

   // Shift amount is frozen at the first sample of a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_q_r <= 8'd0;
      end else if (load && !clr) begin
         sa_q_r <= sa;
      end
   end

endmodule

// File: rtl/avg_sched.sv
// avg_sched -- schedules NS serial accumulations and NSH right shifts over
// a shared datapath, then presents the low DW bits as a frame result.
// Ports:
//   Clk, Rst            : clock, asynchronous active-high reset
//   clear               : synchronous frame abort (beats any handshake)
//   in_data/in_valid/in_ready : sample input handshake
//   sa                  : shift amount, captured with the first sample
//   avg/out_valid/out_ready   : registered result handshake
//   busy                : high whenever the FSM is not IDLE
//   count               : samples accepted in the current frame
module avg_sched
   import avg_pkg::*;
#(
   parameter int DW  = 16,
   parameter int AW  = 32,
   parameter int NS  = NS_DEF,
   parameter int NSH = NSH_DEF
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  clear,
   input  logic [DW-1:0]         in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            sa,
   output logic [DW-1:0]         avg,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic [$clog2(NS)-1:0] count
);

   localparam int CW  = $clog2(NS);
   localparam int SCW = (NSH > 1) ? $clog2(NSH) : 1;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [SCW-1:0] shift_cnt_r;
   logic           accept_s;
   logic           last_sample_s;
   logic           shift_last_s;
   logic           load_s;
   logic           add_s;
   logic           shift_s;
   logic [AW-1:0]  shifted_s;

   // clear masks the input handshake so an abort never starts a frame.
   assign accept_s      = in_valid && in_ready && !clear;
   assign last_sample_s = (count == CW'(NS - 1));
   assign shift_last_s  = (shift_cnt_r == SCW'(NSH - 1));

   // FSM state register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      if (clear) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = accept_s ? ACC : IDLE;
            ACC:     state_nxt_s = (accept_s && last_sample_s) ? SHIFT : ACC;
            SHIFT:   state_nxt_s = shift_last_s ? DONE : SHIFT;
            DONE:    state_nxt_s = (out_valid && out_ready) ? IDLE : DONE;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // FSM outputs: datapath enables and status decode.
   always_comb begin
      load_s   = 1'b0;
      add_s    = 1'b0;
      shift_s  = 1'b0;
      in_ready = 1'b0;
      busy     = 1'b1;
      case (state_r)
         IDLE: begin
            load_s   = accept_s;
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         ACC: begin
            add_s    = accept_s;
            in_ready = 1'b1;
         end
         SHIFT: begin
            shift_s = !clear;
         end
         DONE: begin
            shift_s = 1'b0;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // Sample counter; wraps to zero on the last sample of a frame.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         count <= {CW{1'b0}};
      end else if (clear) begin
         count <= {CW{1'b0}};
      end else if (load_s) begin
         count <= CW'(1);
      end else if (add_s) begin
         count <= count + CW'(1);
      end
   end

   // Shift pass counter, only advances while in SHIFT.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         shift_cnt_r <= {SCW{1'b0}};
      end else if (clear || !shift_s || shift_last_s) begin
         shift_cnt_r <= {SCW{1'b0}};
      end else begin
         shift_cnt_r <= shift_cnt_r + SCW'(1);
      end
   end

   // Result register: captured from the shifter output on the final pass.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         avg       <= {DW{1'b0}};
         out_valid <= 1'b0;
      end else if (clear) begin
         out_valid <= 1'b0;
      end else if (shift_s && shift_last_s) begin
         avg       <= shifted_s[DW-1:0];
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   avg_dp #(
      .DW(DW),
      .AW(AW)
   ) u_dp (
      .clk    (Clk),
      .rst    (Rst),
      .clr    (clear),
      .load   (load_s),
      .add    (add_s),
      .shift  (shift_s),
      .din    (in_data),
      .sa     (sa),
      .shifted(shifted_s)
   );

endmodule

// File: tb/tb_avg_sched.sv
// tb_avg_sched -- scoreboard bench for avg_sched: expected averages are
// queued as frames are driven and compared when out_valid rises.
module tb_avg_sched;

   logic        Clk;
   logic        Rst;
   logic        clear;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  sa;
   logic [15:0] avg;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   logic [15:0] sb[$];

   avg_sched dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .clear    (clear),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .sa       (sa),
      .avg      (avg),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy),
      .count    (count)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Reference: 32-bit wrapping sum, three logical shifts, low 16 bits.
   function automatic logic [15:0] model_avg(input logic [7:0][15:0] s, input logic [7:0] sh);
      logic [31:0] a;
      a = 32'd0;
      for (int i = 0; i < 8; i++) a = a + {16'd0, s[i]};
      for (int j = 0; j < 3; j++) a = (sh >= 8'd32) ? 32'd0 : (a >> sh);
      return a[15:0];
   endfunction

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0][15:0] s, input int n, input logic [7:0] sa0,
                             input logic [7:0] sa1, input bit bubbles);
      logic [2:0] ec;
      for (int i = 0; i < n; i++) begin
         if (bubbles) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
         end
         in_valid = 1'b1;
         in_data  = s[i];
         sa       = (i == 0) ? sa0 : sa1;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_frame got %b exp 1 (sample %0d)", in_ready, i);
         end
         step();
         ec = 3'((i + 1) % 8);
         checks++;
         if (count !== ec) begin
            errors++;
            $display("FAIL count got %0d exp %0d", count, ec);
         end
      end
      in_valid = 1'b0;
   endtask

   // Wait for the result, check latency and value, optionally hold it off.
   task automatic collect(input int hold, input bit poke);
      int n;
      logic [15:0] exp_v;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL latency got %0d edges exp 3", n);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got 0 entries exp 1");
         exp_v = 16'hxxxx;
      end else begin
         exp_v = sb.pop_front();
      end
      checks++;
      if (avg !== exp_v) begin
         errors++;
         $display("FAIL avg got %h exp %h", avg, exp_v);
      end
      if (poke) in_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || avg !== exp_v || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold got ov=%b avg=%h rdy=%b exp ov=1 avg=%h rdy=0", out_valid, avg, in_ready, exp_v);
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL handshake got ov=%b busy=%b cnt=%0d exp 0 0 0", out_valid, busy, count);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (avg !== 16'd0 || out_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset got avg=%h ov=%b busy=%b cnt=%0d rdy=%b exp 0 0 0 0 1",
                  avg, out_valid, busy, count, in_ready);
      end
   endtask

   task automatic test_basic();
      logic [7:0][15:0] s;
      for (int i = 0; i < 8; i++) s[i] = 16'(i + 1);
      send_frame(s, 8, 8'd1, 8'd1, 1'b0);
      sb.push_back(16'd4);
      collect(0, 1'b0);
   endtask

   task automatic test_trunc();
      logic [7:0][15:0] s;
      for (int i = 0; i < 8; i++) s[i] = 16'hFFFF;
      send_frame(s, 8, 8'd0, 8'd0, 1'b0);
      sb.push_back(16'hFFF8);
      checks++;
      if (dut.u_dp.acc_r !== 32'h0007FFF8) begin
         errors++;
         $display("FAIL acc_sum got %h exp 0007fff8", dut.u_dp.acc_r);
      end
      collect(0, 1'b0);
   endtask

   task automatic test_big_shift();
      logic [7:0][15:0] s;
      for (int i = 0; i < 8; i++) s[i] = 16'((i + 1) * 100);
      send_frame(s, 8, 8'd40, 8'd40, 1'b0);
      sb.push_back(16'd0);
      collect(0, 1'b0);
      // sa wiggles after the first sample must not matter.
      send_frame(s, 8, 8'd2, 8'd40, 1'b0);
      sb.push_back(16'd56);
      collect(0, 1'b0);
   endtask

   task automatic test_hold();
      logic [7:0][15:0] s;
      for (int i = 0; i < 8; i++) s[i] = 16'((i + 1) * 5);
      send_frame(s, 8, 8'd1, 8'd1, 1'b0);
      sb.push_back(16'd22);
      collect(5, 1'b1);
      for (int i = 0; i < 8; i++) s[i] = 16'(i + 1);
      send_frame(s, 8, 8'd1, 8'd1, 1'b0);
      sb.push_back(16'd4);
      collect(0, 1'b0);
   endtask

   task automatic test_rst_mid();
      logic [7:0][15:0] s;
      for (int i = 0; i < 8; i++) s[i] = 16'd10;
      send_frame(s, 4, 8'd3, 8'd3, 1'b0);
      #2 Rst = 1'b1;
      #1;
      checks++;
      if (avg !== 16'd0 || out_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0 ||
          in_ready !== 1'b1 || dut.u_dp.acc_r !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid got avg=%h ov=%b busy=%b cnt=%0d rdy=%b exp 0 0 0 0 1",
                  avg, out_valid, busy, count, in_ready);
      end
      Rst = 1'b0;
      step();
      send_frame(s, 8, 8'd3, 8'd3, 1'b0);
      sb.push_back(16'd0);
      collect(0, 1'b0);
   endtask

   task automatic test_clear_and_bubbles();
      logic [7:0][15:0] s;
      logic [15:0] prev;
      logic [7:0] shr;
      for (int i = 0; i < 8; i++) s[i] = 16'(i + 1);
      send_frame(s, 8, 8'd1, 8'd1, 1'b0);
      prev = avg;
      step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      checks++;
      if (busy !== 1'b0 || count !== 3'd0 || out_valid !== 1'b0 || avg !== prev ||
          dut.u_dp.acc_r !== 32'd0) begin
         errors++;
         $display("FAIL clear got busy=%b cnt=%0d ov=%b avg=%h exp 0 0 0 %h", busy, count, out_valid, avg, prev);
      end
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_pulse got %b exp 0", out_valid);
         end
      end
      for (int i = 0; i < 8; i++) s[i] = 16'($urandom_range(0, 65535));
      shr = 8'($urandom_range(0, 4));
      send_frame(s, 8, shr, 8'($urandom_range(0, 255)), 1'b1);
      sb.push_back(model_avg(s, shr));
      collect(0, 1'b0);
      send_frame(s, 8, shr, shr, 1'b0);
      sb.push_back(model_avg(s, shr));
      collect(0, 1'b0);
   endtask

   initial begin
      Rst       = 1'b1;
      clear     = 1'b0;
      in_data   = 16'd0;
      in_valid  = 1'b0;
      sa        = 8'd0;
      out_ready = 1'b0;
      #1;
      test_reset();
      step();
      Rst = 1'b0;
      step();
      test_basic();
      test_trunc();
      test_big_shift();
      test_hold();
      test_rst_mid();
      test_clear_and_bubbles();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
